uart_transmitter: RTL

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/baud_controller.sv | 29 ++
 rtl/uart_transmitter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, frame constants
// and the baud_select code table (clock cycles per oversample tick).
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   localparam int DATA_BITS      = 8;
   localparam int OVERSAMPLE_DEF = 16;
   localparam int FRAME_BITS     = 11;

   localparam logic [2:0] BAUD_9600   = 3'b000;
   localparam logic [2:0] BAUD_19200  = 3'b001;
   localparam logic [2:0] BAUD_38400  = 3'b010;
   localparam logic [2:0] BAUD_57600  = 3'b011;
   localparam logic [2:0] BAUD_115200 = 3'b100;
   localparam logic [2:0] BAUD_230400 = 3'b101;
   localparam logic [2:0] BAUD_1M56   = 3'b110;
   localparam logic [2:0] BAUD_3M125  = 3'b111;

   // Divisors assume a 50 MHz clock and 16x oversampling.
   function automatic logic [8:0] baud_divisor(input logic [2:0] sel);
      logic [8:0] div;
      case (sel)
         BAUD_9600:   div = 9'd326;
         BAUD_19200:  div = 9'd163;
         BAUD_38400:  div = 9'd81;
         BAUD_57600:  div = 9'd54;
         BAUD_115200: div = 9'd27;
         BAUD_230400: div = 9'd14;
         BAUD_1M56:   div = 9'd2;
         default:     div = 9'd1;
      endcase
      return div;
   endfunction

endpackage

// File: rtl/baud_controller.sv
// Oversample tick generator: one-cycle sample_ENABLE pulse every
// baud_divisor(baud_select) clock cycles.
module baud_controller
   import uart_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] baud_select,
   output logic       sample_ENABLE
);

   logic [8:0] div_cnt;
   logic [8:0] div_lim;

   assign div_lim = baud_divisor(baud_select) - 9'd1;

   // >= so a switch to a faster rate mid-count still produces a tick promptly
   assign sample_ENABLE = (div_cnt >= div_lim);

   always_ff @(posedge clock) begin
      if (reset)
         div_cnt <= 9'd0;
      else if (sample_ENABLE)
         div_cnt <= 9'd0;
      else
         div_cnt <= div_cnt + 9'd1;
   end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter, 8 data bits + even parity + 1 stop, OVERSAMPLE ticks per bit.
// Build option UART_TX_FIFO_EN: FIFO_DEPTH-entry holding FIFO instead of one register.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] Tx_DATA,
   input  logic                 Tx_WR,
   input  logic                 Tx_EN,
   input  logic [2:0]           baud_select,
   output logic                 TxD,
   output logic                 Tx_READY,
   output logic                 Tx_BUSY
);

   localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);

   if ((OVERSAMPLE < 2) || (OVERSAMPLE > 16)) begin : g_bad_oversample
      $error("OVERSAMPLE must lie in 2..16");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two >= 2");
   end

   logic                 tick;
   tx_state_t            state, state_nxt;
   logic [3:0]           tick_cnt, cnt_nxt;
   logic [2:0]           bit_idx, idx_nxt;
   logic [DATA_BITS-1:0] shift_reg, shift_nxt;
   logic                 parity_bit, parity_nxt;
   logic                 txd_nxt;
   logic                 bit_end;
   logic                 start_frame;
   logic                 pending;
   logic                 accept;
   logic                 pop;
   logic [DATA_BITS-1:0] head;

   baud_controller u_baud (
      .clock         (clock),
      .reset         (reset),
      .baud_select   (baud_select),
      .sample_ENABLE (tick)
   );

   assign accept = Tx_WR & Tx_READY;
   assign pop    = start_frame;

`ifdef UART_TX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW:0]          wr_ptr, rd_ptr;
   logic                 full;

   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pending  = (wr_ptr != rd_ptr);
   assign head     = fifo_mem[rd_ptr[AW-1:0]];
   // A pop frees the slot being read, so a write can land there the same cycle.
   assign Tx_READY = ~full | pop;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)    rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (accept) fifo_mem[wr_ptr[AW-1:0]] <= Tx_DATA;
   end
`else
   logic                 hold_valid;
   logic [DATA_BITS-1:0] hold_data;

   assign pending  = hold_valid;
   assign head     = hold_data;
   assign Tx_READY = ~hold_valid;

   always_ff @(posedge clock) begin
      if (reset)
         hold_valid <= 1'b0;
      else if (accept)
         hold_valid <= 1'b1;
      else if (pop)
         hold_valid <= 1'b0;
   end

   always_ff @(posedge clock) begin
      if (accept) hold_data <= Tx_DATA;
   end
`endif

   assign bit_end = tick && (tick_cnt == OS_LAST);
   assign Tx_BUSY = (state != ST_IDLE);

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = tick_cnt;
      idx_nxt     = bit_idx;
      shift_nxt   = shift_reg;
      parity_nxt  = parity_bit;
      txd_nxt     = TxD;
      start_frame = 1'b0;
      if (tick) begin
         cnt_nxt = bit_end ? 4'd0 : tick_cnt + 4'd1;
         unique case (state)
            ST_IDLE: begin
               cnt_nxt     = 4'd0;
               start_frame = Tx_EN & pending;
            end
            ST_START: if (bit_end) begin
               state_nxt = ST_DATA;
               idx_nxt   = 3'd0;
               txd_nxt   = shift_reg[0];
            end
            ST_DATA: if (bit_end) begin
               if (bit_idx == 3'd7) begin
                  state_nxt = ST_PARITY;
                  txd_nxt   = parity_bit;
               end else begin
                  idx_nxt   = bit_idx + 3'd1;
                  shift_nxt = shift_reg >> 1;
                  txd_nxt   = shift_reg[1];
               end
            end
            ST_PARITY: if (bit_end) begin
               state_nxt = ST_STOP;
               txd_nxt   = 1'b1;
            end
            ST_STOP: if (bit_end) begin
               state_nxt   = ST_IDLE;
               start_frame = Tx_EN & pending;
            end
            default: state_nxt = ST_IDLE;
         endcase
         // Shared by IDLE and the back-to-back STOP exit: no idle gap after stop.
         if (start_frame) begin
            state_nxt  = ST_START;
            cnt_nxt    = 4'd0;
            idx_nxt    = 3'd0;
            txd_nxt    = 1'b0;
            shift_nxt  = head;
            parity_nxt = ^head;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         tick_cnt <= 4'd0;
         bit_idx  <= 3'd0;
         TxD      <= 1'b1;
      end else begin
         state    <= state_nxt;
         tick_cnt <= cnt_nxt;
         bit_idx  <= idx_nxt;
         TxD      <= txd_nxt;
      end
   end

   always_ff @(posedge clock) begin
      shift_reg  <= shift_nxt;
      parity_bit <= parity_nxt;
   end

endmodule
